// File: rtl/uart_tx_parity_if.sv
// +-----------------------------------------------------------------------------
// | Module   : uart_tx_parity_if
// | Brief    : Handshake and serial-line bundle for the parity UART transmitter.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

interface uart_tx_parity_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  parity_en;
    logic                  is_even_parity;
    logic                  tx_ready;
    logic                  tx_done;
    logic                  TXD;

    modport master (
        output tx_valid,
        output tx_data,
        output parity_en,
        output is_even_parity,
        input  tx_ready,
        input  tx_done,
        input  TXD
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  parity_en,
        input  is_even_parity,
        output tx_ready,
        output tx_done,
        output TXD
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_parity.sv
// +-----------------------------------------------------------------------------
// | Module   : uart_tx_parity
// | Brief    : UART transmitter, LSB first, optional even/odd parity, 1-2 stops.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module uart_tx_parity #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input wire              HCLK,
    input wire              HRESETn,
    uart_tx_parity_if.slave bus
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W = $clog2(DATA_WIDTH + 5);

    localparam logic [c_CNT_W-1:0] c_CLK_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_WIDTH);
    localparam logic [c_BIT_W-1:0] c_STOP_BASE = c_BIT_W'(DATA_WIDTH + STOP_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [c_CNT_W-1:0]    r_clk_cnt,    w_clk_cnt_nxt;
    logic [c_BIT_W-1:0]    r_bit_cnt,    w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift,      w_shift_nxt;
    logic                  r_parity_en,  w_parity_en_nxt;
    logic                  r_parity_bit, w_parity_bit_nxt;
    logic                  r_txd,        w_txd_nxt;
    logic                  r_done,       w_done_nxt;
    logic                  w_bit_end;
    logic [c_BIT_W-1:0]    w_last_bit;

    // Index of the final stop bit within the frame (start bit is index 0).
    assign w_last_bit = c_STOP_BASE + {{(c_BIT_W-1){1'b0}}, r_parity_en};
    assign w_bit_end  = (r_clk_cnt == c_CLK_LAST);

    always_comb begin
        w_state_nxt      = r_state;
        w_clk_cnt_nxt    = r_clk_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_parity_en_nxt  = r_parity_en;
        w_parity_bit_nxt = r_parity_bit;
        w_txd_nxt        = r_txd;
        w_done_nxt       = 1'b0;

        if (r_state != S_IDLE) begin
            if (w_bit_end) begin
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end else begin
                w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                w_txd_nxt     = 1'b1;
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
                // tx_ready is exactly "state is IDLE", so valid alone accepts here.
                if (bus.tx_valid) begin
                    w_state_nxt      = S_START;
                    w_txd_nxt        = 1'b0;
                    w_shift_nxt      = bus.tx_data;
                    w_parity_en_nxt  = bus.parity_en;
                    w_parity_bit_nxt = bus.is_even_parity ? (^bus.tx_data) : (~^bus.tx_data);
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_DATA_LAST) begin
                        if (r_parity_en) begin
                            w_state_nxt = S_PARITY;
                            w_txd_nxt   = r_parity_bit;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_txd_nxt   = 1'b1;
                        end
                    end else begin
                        w_txd_nxt   = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
            S_STOP: begin
                w_txd_nxt = 1'b1;
                if (w_bit_end && (r_bit_cnt == w_last_bit)) begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = '0;
                    w_done_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_txd_nxt     = 1'b1;
                w_clk_cnt_nxt = '0;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity_en  <= 1'b0;
            r_parity_bit <= 1'b0;
            r_txd        <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clk_cnt    <= w_clk_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_parity_en  <= w_parity_en_nxt;
            r_parity_bit <= w_parity_bit_nxt;
            r_txd        <= w_txd_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.tx_ready = (r_state == S_IDLE);
    assign bus.tx_done  = r_done;
    assign bus.TXD      = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_parity.sv
// +-----------------------------------------------------------------------------
// | Module   : tb_uart_tx_parity
// | Brief    : Directed vector bench for uart_tx_parity (1 and 2 stop-bit builds).
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_parity;

    localparam int CPB = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    uart_tx_parity_if #(.DATA_WIDTH(8)) if1 ();
    uart_tx_parity_if #(.DATA_WIDTH(8)) if2 ();

    uart_tx_parity #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if1)
    );

    uart_tx_parity #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        even;
        logic [12:0] frame;   // bit i = expected TXD during frame bit i
        int          nbits;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send1(input logic [7:0] d, input logic pen, input logic ev);
        int n;
        n = 0;
        @(negedge clk);
        while (!if1.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if1.tx_ready) chk("wait_ready", 32'd0, 32'd1);
        if1.tx_data        = d;
        if1.parity_en      = pen;
        if1.is_even_parity = ev;
        if1.tx_valid       = 1'b1;
        @(posedge clk);
        #1 if1.tx_valid = 1'b0;
    endtask

    // Call just after the acceptance edge; ends at the negedge of the tx_done cycle.
    task automatic check_frame(input logic [12:0] frame, input int nbits, input string tag);
        for (int c = 1; c <= nbits * CPB; c++) begin
            @(negedge clk);
            chk($sformatf("%s txd c%0d", tag, c), if1.TXD, frame[(c-1)/CPB]);
            chk($sformatf("%s ready c%0d", tag, c), if1.tx_ready, 1'b0);
            chk($sformatf("%s done c%0d", tag, c), if1.tx_done, 1'b0);
        end
        @(negedge clk);
        chk($sformatf("%s done_pulse", tag), if1.tx_done, 1'b1);
        chk($sformatf("%s done_ready", tag), if1.tx_ready, 1'b1);
        chk($sformatf("%s done_txd", tag), if1.TXD, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 13'h034A, 10};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 13'h054A, 11};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 13'h074A, 11};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 13'h060E, 11};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 13'h040E, 11};
        vecs[5] = '{8'h07, 1'b0, 1'b1, 13'h020E, 10};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 13'h05FE, 11};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 13'h07FE, 11};

        if1.tx_valid = 1'b0; if1.tx_data = '0; if1.parity_en = 1'b0; if1.is_even_parity = 1'b0;
        if2.tx_valid = 1'b0; if2.tx_data = '0; if2.parity_en = 1'b0; if2.is_even_parity = 1'b0;

        // Reset values while held, then idle behaviour after release
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst txd", if1.TXD, 1'b1);
        chk("rst ready", if1.tx_ready, 1'b1);
        chk("rst done", if1.tx_done, 1'b0);
        chk("rst2 txd", if2.TXD, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c % 10 == 0) begin
                chk($sformatf("idle txd c%0d", c), if1.TXD, 1'b1);
                chk($sformatf("idle ready c%0d", c), if1.tx_ready, 1'b1);
                chk($sformatf("idle done c%0d", c), if1.tx_done, 1'b0);
            end
        end

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            send1(vecs[v].data, vecs[v].pen, vecs[v].even);
            check_frame(vecs[v].frame, vecs[v].nbits, $sformatf("vec%0d", v));
            @(negedge clk);
            chk($sformatf("vec%0d done_once", v), if1.tx_done, 1'b0);
        end

        // Two stop bits: 0x00 without parity on the second instance
        @(negedge clk);
        if2.tx_data = 8'h00; if2.parity_en = 1'b0; if2.is_even_parity = 1'b0; if2.tx_valid = 1'b1;
        @(posedge clk);
        #1 if2.tx_valid = 1'b0;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            chk($sformatf("stop2 txd c%0d", c), if2.TXD, (c <= 36) ? 1'b0 : 1'b1);
            chk($sformatf("stop2 done c%0d", c), if2.tx_done, 1'b0);
        end
        @(negedge clk);
        chk("stop2 done_pulse", if2.tx_done, 1'b1);
        chk("stop2 ready", if2.tx_ready, 1'b1);

        // Back-to-back with tx_valid held; data changes after acceptance
        send1(8'h55, 1'b0, 1'b0);
        if1.tx_valid = 1'b1;
        if1.tx_data  = 8'hAA;
        check_frame(13'h02AA, 10, "b2b0");
        @(posedge clk);
        #1 if1.tx_valid = 1'b0;
        check_frame(13'h0354, 10, "b2b1");
        @(negedge clk);
        chk("b2b done_once", if1.tx_done, 1'b0);
        chk("b2b idle_ready", if1.tx_ready, 1'b1);

        // Asynchronous reset during the 4th data bit
        send1(8'h00, 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        chk("midrst txd_before", if1.TXD, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst txd", if1.TXD, 1'b1);
        chk("midrst ready", if1.tx_ready, 1'b1);
        chk("midrst done", if1.tx_done, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("midrst hold done c%0d", c), if1.tx_done, 1'b0);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            chk($sformatf("postrst done c%0d", c), if1.tx_done, 1'b0);
        end
        send1(8'h3C, 1'b0, 1'b0);
        check_frame(13'h0278, 10, "post3c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_parity.md
# uart_tx_parity

Serial UART transmitter with optional parity generation, the transmit-side counterpart of the UART receive path's parity checking inside the AHB UART. It accepts a parallel byte through a valid/ready handshake, latches it, and shifts out a start bit, data bits (LSB first), an optional even/odd parity bit and one or two stop bits on `TXD`. Bit timing comes from an internal clocks-per-bit counter, so no external baud tick is required.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; range 5-9.
- `CLKS_PER_BIT`, 16: `HCLK` cycles per serial bit; range ≥ 2.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `HCLK`  in  1  system clock; all logic is on its rising edge.
- `HRESETn`  in  1  reset, asynchronous assert, active-low.
- `tx_valid`  in  1  `tx_data` and the mode inputs are valid.
- `tx_data`  in  `DATA_WIDTH`  byte to transmit.
- `parity_en`  in  1  1 = insert a parity bit.
- `is_even_parity`  in  1  1 = even parity, 0 = odd parity.
- `tx_ready`  out  1  transmitter idle and able to accept.
- `tx_done`  out  1  one-cycle pulse when a frame completes.
- `TXD`  out  1  serial line; idles high.

## Operation
- Reset values: `TXD`=1, `tx_ready`=1, `tx_done`=0; state IDLE; bit counter, clock counter and shift register cleared.
- Acceptance happens on the rising edge where `tx_valid && tx_ready`. On that edge the block latches `tx_data`, `parity_en` and `is_even_parity`, and computes the parity bit.
- Parity bit values:
  - Even: `^tx_data`, so the total count of ones across data and parity is even.
  - Odd: `~^tx_data`.
- Later changes on any input have no effect on a frame in flight. `tx_valid` is ignored while `tx_ready`=0.
- State machine:
  - IDLE → START on acceptance.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA shifts out `DATA_WIDTH` bits, LSB first. It then goes to PARITY if the latched `parity_en`=1, otherwise to STOP.
  - PARITY → STOP after one bit time.
  - STOP lasts `STOP_BITS` bit times, then returns to IDLE.
- `TXD` per state: IDLE 1, START 0, DATA the current data bit, PARITY the parity bit, STOP 1.
- `TXD` is driven directly from a flop so that no glitches appear on the line.
- Frame length N = 1 + `DATA_WIDTH` + `parity_en` + `STOP_BITS` bits.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously), the frame is abandoned, and `tx_done` does not pulse.

## Timing
- Acceptance edge is edge k.
  - `tx_ready` goes low after edge k.
  - `TXD`=0 for cycles k+1 … k+`CLKS_PER_BIT`.
  - Bit i of the frame (start bit = 0) occupies cycles k+1+i·`CLKS_PER_BIT` … k+(i+1)·`CLKS_PER_BIT`.
- Frame completion, at edge k + N·`CLKS_PER_BIT`:
  - State goes to IDLE.
  - `tx_ready`=1 and `tx_done`=1 in the following cycle only.
  - `TXD` stays 1.
- Back-to-back frames: if `tx_valid` is held high, the next acceptance occurs in the `tx_done` cycle. This gives exactly one idle-high `HCLK` cycle between the last stop bit and the next start bit, so the frame period is N·`CLKS_PER_BIT` + 1 cycles.
- `tx_done` and `tx_ready` are never both asserted outside the first IDLE cycle. `tx_done` is never asserted for two consecutive cycles.
- Counters wrap: the clock counter runs 0 … `CLKS_PER_BIT`−1 and resets at each bit boundary. The bit counter runs 0 … N−1 and resets on entry to IDLE.

## Test plan
- **Reset values:** hold `HRESETn`=0 → `TXD`=1, `tx_ready`=1, `tx_done`=0. Release, leave `tx_valid`=0 for 50 cycles → outputs unchanged.
- **No parity:** `CLKS_PER_BIT`=4, `STOP_BITS`=1, send 0xA5 with `parity_en`=0.
  - `TXD`, sampled every 4 cycles, reads 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses at cycle 41 after acceptance.
  - `tx_ready` is low for cycles 1-40.
- **Parity values:** `parity_en`=1, `CLKS_PER_BIT`=4.
  - 0xA5 even → parity bit 0; 0xA5 odd → parity bit 1.
  - 0x07 even → parity bit 1; 0x07 odd → parity bit 0.
  - Frame is 11 bits; `tx_done` at cycle 45.
- **Two stop bits:** `STOP_BITS`=2, send 0x00 with no parity → `TXD` is low for 9 bits, then high for 8 cycles, then `tx_done` pulses.
- **Back-to-back:** hold `tx_valid`=1 with data 0x55 then 0xAA → second start bit begins exactly 1 cycle after the first `tx_done` cycle. Changing `tx_data` mid-frame does not alter the bits already in flight.
- **Reset mid-frame:** assert `HRESETn`=0 during the 4th data bit → `TXD`=1 and `tx_ready`=1 without waiting for a clock edge, with no `tx_done` pulse. After release, a new 0x3C frame transmits correctly.
